// File: rtl/audio_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module      : audio_voice_mixer
// Description : Multi-voice PCM sample player. Fetches one sample per active
//               voice from a shared single-port sample memory once per
//               output period, sums them with saturation and presents the
//               mix to a codec serializer over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_voice_mixer #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 4,
  parameter int CLK_DIV = 1042
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_stop,
  input  logic [NUM_CH-1:0]        ch_loop,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_len,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [ADDR_W-1:0]        mem_address,
  output logic                     mem_read,
  input  logic [DATA_W-1:0]        mem_readdata,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Three guard bits hold the sum of up to eight full-scale voices.
  localparam int ACC_W  = DATA_W + 3;

  localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0]        SLOT_LAST = SLOT_W'(NUM_CH - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX   = ACC_W'((1 << (DATA_W - 1)) - 1);
  // Bitwise inverse of the positive limit is exactly the negative limit.
  localparam logic signed [ACC_W-1:0]  SAT_MIN   = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_SAT  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          tick;

  logic [NUM_CH-1:0]             start_pend_q, start_pend_d;
  logic [NUM_CH-1:0]             stop_pend_q, stop_pend_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] pend_base_q, pend_base_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] pend_len_q, pend_len_d;
  logic [NUM_CH-1:0]             pend_loop_q, pend_loop_d;

  logic [NUM_CH-1:0]             active_q, active_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] base_q, base_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] len_q, len_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] ptr_q, ptr_d;
  logic [NUM_CH-1:0]             loop_q, loop_d;

  state_t                        state_q, state_d;
  logic [SLOT_W-1:0]             slot_q, slot_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [ADDR_W-1:0]             addr_hold_q, addr_hold_d;

  logic [DATA_W-1:0]             out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          overrun_q, overrun_d;

  // Free-running sample-period divider; tick marks the last count.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Capture start/stop pulses and start parameters until the next tick.
  always_comb begin
    start_pend_d = (tick ? '0 : start_pend_q) | ch_start;
    stop_pend_d  = (tick ? '0 : stop_pend_q)  | ch_stop;
    pend_base_d  = pend_base_q;
    pend_len_d   = pend_len_q;
    pend_loop_d  = pend_loop_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_start[i]) begin
        pend_base_d[i] = ch_base[i*ADDR_W +: ADDR_W];
        pend_len_d[i]  = ch_len[i*ADDR_W +: ADDR_W];
        pend_loop_d[i] = ch_loop[i];
      end
    end
  end

  // Voice bookkeeping, frame sequencer, memory strobes and output register.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    acc_d       = acc_q;
    active_d    = active_q;
    base_d      = base_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    loop_d      = loop_q;
    addr_hold_d = addr_hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    mem_read    = 1'b0;
    mem_address = addr_hold_q;

    // Consumer took the sample.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Pending requests land on the tick, ahead of the frame it launches.
    // The frame is always finished before the next tick, so voice state
    // never changes under a running frame.
    if (tick) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (stop_pend_q[i]) begin
          active_d[i] = 1'b0;
        end else if (start_pend_q[i] && (pend_len_q[i] != '0)) begin
          active_d[i] = 1'b1;
          ptr_d[i]    = '0;
          base_d[i]   = pend_base_q[i];
          len_d[i]    = pend_len_q[i];
          loop_d[i]   = pend_loop_q[i];
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (out_valid_q) begin
            // Previous mix still unclaimed: drop this frame, keep pointers.
            overrun_d = 1'b1;
          end else begin
            state_d = ST_ADDR;
            slot_d  = '0;
            acc_d   = '0;
          end
        end
      end

      ST_ADDR: begin
        if (active_q[slot_q]) begin
          mem_read    = 1'b1;
          mem_address = base_q[slot_q] + ptr_q[slot_q];
          addr_hold_d = base_q[slot_q] + ptr_q[slot_q];
        end
        state_d = ST_DATA;
      end

      ST_DATA: begin
        if (active_q[slot_q]) begin
          acc_d = acc_q + {{(ACC_W-DATA_W){mem_readdata[DATA_W-1]}}, mem_readdata};
          if (ptr_q[slot_q] == len_q[slot_q] - 1'b1) begin
            ptr_d[slot_q]    = '0;
            active_d[slot_q] = loop_q[slot_q];
          end else begin
            ptr_d[slot_q] = ptr_q[slot_q] + 1'b1;
          end
        end
        if (slot_q == SLOT_LAST) begin
          state_d = ST_SAT;
        end else begin
          slot_d  = slot_q + 1'b1;
          state_d = ST_ADDR;
        end
      end

      ST_SAT: begin
        if (acc_q > SAT_MAX) begin
          out_data_d = SAT_MAX[DATA_W-1:0];
        end else if (acc_q < SAT_MIN) begin
          out_data_d = SAT_MIN[DATA_W-1:0];
        end else begin
          out_data_d = acc_q[DATA_W-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      start_pend_q <= '0;
      stop_pend_q  <= '0;
      pend_base_q  <= '0;
      pend_len_q   <= '0;
      pend_loop_q  <= '0;
      active_q     <= '0;
      base_q       <= '0;
      len_q        <= '0;
      ptr_q        <= '0;
      loop_q       <= '0;
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      acc_q        <= '0;
      addr_hold_q  <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      pend_base_q  <= pend_base_d;
      pend_len_q   <= pend_len_d;
      pend_loop_q  <= pend_loop_d;
      active_q     <= active_d;
      base_q       <= base_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      loop_q       <= loop_d;
      state_q      <= state_d;
      slot_q       <= slot_d;
      acc_q        <= acc_d;
      addr_hold_q  <= addr_hold_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ch_busy   = active_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_voice_mixer
// Description : Directed self-checking bench for audio_voice_mixer with a
//               synchronous-read sample memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_voice_mixer;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 16;
  localparam int NUM_CH  = 4;
  localparam int CLK_DIV = 24;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        ch_start, ch_stop, ch_loop;
  logic [NUM_CH*ADDR_W-1:0] ch_base, ch_len;
  logic [NUM_CH-1:0]        ch_busy;
  logic [ADDR_W-1:0]        mem_address;
  logic                     mem_read;
  logic [DATA_W-1:0]        mem_readdata;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overrun;

  logic [DATA_W-1:0]        mem [0:1023];
  int                       rd_cnt = 0;
  int                       total = 0;
  int                       bad = 0;
  int                       rd_snap;
  bit                       seen;

  audio_voice_mixer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .reset(reset),
    .ch_start(ch_start), .ch_stop(ch_stop), .ch_loop(ch_loop),
    .ch_base(ch_base), .ch_len(ch_len), .ch_busy(ch_busy),
    .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Sample memory: one-cycle synchronous read; also counts read strobes.
  always @(posedge clk) begin
    if (mem_read) begin
      mem_readdata <= mem[mem_address[9:0]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_voice(input int ch, input logic [ADDR_W-1:0] base,
                           input logic [ADDR_W-1:0] len, input logic lp);
    ch_base[ch*ADDR_W +: ADDR_W] = base;
    ch_len[ch*ADDR_W +: ADDR_W]  = len;
    ch_loop[ch]                  = lp;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp);
    ch_start = st;
    ch_stop  = sp;
    step(1);
    ch_start = '0;
    ch_stop  = '0;
  endtask

  // Wait (bounded) for the next mixed sample and compare it.
  task automatic expect_sample(input string tag, input logic [DATA_W-1:0] exp);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 4*CLK_DIV; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_arrived"}, {31'd0, got}, 32'd1);
    if (got) check(tag, {16'd0, out_data}, {16'd0, exp});
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    mem[10'h100] = 16'h0064;   //  100
    mem[10'h101] = 16'hFF38;   // -200
    mem[10'h102] = 16'h012C;   //  300
    mem[10'h010] = 16'h7000;
    mem[10'h020] = 16'h9000;

    reset = 1'b1; ch_start = '0; ch_stop = '0; ch_loop = '0;
    ch_base = '0; ch_len = '0; out_ready = 1'b1;
    step(3);
    check("rst_valid",   {31'd0, out_valid}, 32'd0);
    check("rst_busy",    {28'd0, ch_busy},   32'd0);
    check("rst_memread", {31'd0, mem_read},  32'd0);
    check("rst_overrun", {31'd0, overrun},   32'd0);
    check("rst_data",    {16'd0, out_data},  32'd0);
    check("rst_addr",    {14'd0, mem_address}, 32'd0);
    reset = 1'b0;

    // Reset in the middle of a frame (during DATA of slot 1).
    set_voice(0, 18'h100, 18'd3, 1'b1);
    pulse(4'b0001, 4'b0000);
    seen = 1'b0;
    for (int n = 0; n < 3*CLK_DIV; n++) begin
      step(1);
      if (mem_read) begin
        seen = 1'b1;
        break;
      end
    end
    check("midrst_frame_seen", {31'd0, seen}, 32'd1);
    step(3);
    reset = 1'b1;
    step(1);
    check("midrst_valid",   {31'd0, out_valid}, 32'd0);
    check("midrst_busy",    {28'd0, ch_busy},   32'd0);
    check("midrst_memread", {31'd0, mem_read},  32'd0);
    reset = 1'b0;
    expect_sample("midrst_silence", 16'h0000);

    // One-shot voice.
    set_voice(0, 18'h100, 18'd3, 1'b0);
    pulse(4'b0001, 4'b0000);
    expect_sample("once_s0", 16'h0064);
    check("once_busy_on", {28'd0, ch_busy}, 32'h1);
    expect_sample("once_s1", 16'hFF38);
    expect_sample("once_s2", 16'h012C);
    check("once_busy_off", {28'd0, ch_busy}, 32'h0);
    expect_sample("once_s3", 16'h0000);

    // Looping voice, then stop.
    set_voice(0, 18'h100, 18'd3, 1'b1);
    pulse(4'b0001, 4'b0000);
    expect_sample("loop_s0", 16'h0064);
    expect_sample("loop_s1", 16'hFF38);
    expect_sample("loop_s2", 16'h012C);
    expect_sample("loop_s3", 16'h0064);
    check("loop_busy", {28'd0, ch_busy}, 32'h1);
    pulse(4'b0000, 4'b0001);
    expect_sample("loop_stopped", 16'h0000);
    check("loop_busy_off", {28'd0, ch_busy}, 32'h0);

    // Saturation at both rails, then an in-range two-voice mix.
    for (int c = 0; c < NUM_CH; c++) set_voice(c, 18'h010, 18'd1, 1'b1);
    pulse(4'b1111, 4'b0000);
    expect_sample("sat_pos", 16'h7FFF);
    for (int c = 0; c < NUM_CH; c++) set_voice(c, 18'h020, 18'd1, 1'b1);
    pulse(4'b1111, 4'b0000);
    expect_sample("sat_neg", 16'h8000);
    check("sat_busy", {28'd0, ch_busy}, 32'hF);
    set_voice(0, 18'h100, 18'd1, 1'b1);
    set_voice(1, 18'h101, 18'd1, 1'b1);
    pulse(4'b0011, 4'b1100);
    expect_sample("mix_two", 16'hFF9C);
    check("mix_busy", {28'd0, ch_busy}, 32'h3);
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);
    pulse(4'b0000, 4'b1111);
    expect_sample("mix_silence", 16'h0000);

    // Back-pressure across two ticks.
    set_voice(0, 18'h100, 18'd3, 1'b1);
    pulse(4'b0001, 4'b0000);
    expect_sample("bp_s0", 16'h0064);
    step(1);
    out_ready = 1'b0;
    step(3*CLK_DIV - 2);
    check("bp_valid_held", {31'd0, out_valid}, 32'd1);
    check("bp_data_held",  {16'd0, out_data},  32'h0000FF38);
    check("bp_overrun",    {31'd0, overrun},   32'd1);
    out_ready = 1'b1;
    step(1);
    expect_sample("bp_s2", 16'h012C);
    expect_sample("bp_s3", 16'h0064);
    check("bp_overrun_sticky", {31'd0, overrun}, 32'd1);
    pulse(4'b0000, 4'b0001);
    expect_sample("bp_silence", 16'h0000);

    // Start+stop together on voice 2, zero-length start on voice 3.
    rd_snap = rd_cnt;
    set_voice(2, 18'h200, 18'd3, 1'b1);
    set_voice(3, 18'h300, 18'd0, 1'b1);
    pulse(4'b1100, 4'b0100);
    expect_sample("ign_s0", 16'h0000);
    expect_sample("ign_s1", 16'h0000);
    check("ign_busy",  {28'd0, ch_busy}, 32'h0);
    check("ign_reads", rd_cnt - rd_snap, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
